// File: rtl/jtag_host.sv
// jtag_host -- JTAG initiator for the MCU debug port.
//
// Sequences one command at a time through the port's state machine
// (Idle -> Select -> Shift -> Update -> Idle). Drives tck/tms/tdi and
// captures tdo MSB-first.
//
// Timing:
//   - One tck period is 2*TCK_HALF clks and starts with tck low.
//   - tms/tdi change on the first clk of the low phase.
//   - tdo is sampled on the last clk of the low phase.
//   - tck is high for the second half of the period.
//   - From the accepting edge (cmd_valid & cmd_ready sampled high) to the
//     edge that raises rsp_valid is exactly 40*TCK_HALF clks for a data
//     shift and 22*TCK_HALF clks for an instruction shift.
//   - cmd_ready returns one clk after the rsp_valid pulse.
//
// Ports:
//   clk, rst             system clock, synchronous active-high reset
//   cmd_valid/cmd_ready  command handshake
//   cmd_isData           1 = 16-bit data shift, 0 = 8-bit instruction shift
//   cmd_payload          bits to shift (instruction uses [7:0])
//   rsp_valid            one-clk completion pulse
//   rsp_data             captured tdo bits (instruction zero-extended)
//   busy                 transaction or reset sequence in progress
//   tck, tms, tdi, tdo   JTAG pins (tdo already synchronous to clk)
module jtag_host #(
    parameter int TCK_HALF = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_isData,
    input  logic [15:0] cmd_payload,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic        busy,
    output logic        tck,
    output logic        tms,
    output logic        tdi,
    input  logic        tdo
);
    localparam int PERIOD = 2 * TCK_HALF;
    localparam int PW     = $clog2(PERIOD);
    localparam logic [PW-1:0] LOW_END    = PW'(TCK_HALF - 1);
    localparam logic [PW-1:0] PERIOD_END = PW'(PERIOD - 1);

    typedef enum logic [2:0] {RST_SEQ, IDLE, SEL_I, SEL_D, SHIFT, UPDATE} stateT;

    stateT         state, stateNext;
    logic [PW-1:0] phase, phaseNext;
    // Period counter within a state: RST_SEQ periods, SEL_I lead-in, shift bits.
    logic [3:0]    cnt, cntNext;
    logic          isData, isDataNext;
    logic [15:0]   shifter, shifterNext;
    logic [15:0]   capture, captureNext;
    logic          tckNext, tmsNext, tdiNext, readyNext, rspValidNext;
    logic [15:0]   rspDataNext;
    logic [3:0]    lastBit, lastBitNext;

    // Outside reset and IDLE-with-ready, the host is always mid-operation.
    assign busy        = ~cmd_ready;
    assign lastBit     = isData ? 4'd15 : 4'd7;
    assign lastBitNext = isDataNext ? 4'd15 : 4'd7;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RST_SEQ;
            phase     <= '0;
            cnt       <= '0;
            isData    <= 1'b0;
            shifter   <= '0;
            capture   <= '0;
            tck       <= 1'b0;
            tms       <= 1'b1;
            tdi       <= 1'b0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            state     <= stateNext;
            phase     <= phaseNext;
            cnt       <= cntNext;
            isData    <= isDataNext;
            shifter   <= shifterNext;
            capture   <= captureNext;
            tck       <= tckNext;
            tms       <= tmsNext;
            tdi       <= tdiNext;
            cmd_ready <= readyNext;
            rsp_valid <= rspValidNext;
            rsp_data  <= rspDataNext;
        end
    end

    always_comb begin
        stateNext    = state;
        phaseNext    = phase;
        cntNext      = cnt;
        isDataNext   = isData;
        shifterNext  = shifter;
        captureNext  = capture;
        tckNext      = tck;
        readyNext    = cmd_ready;
        rspValidNext = 1'b0;
        rspDataNext  = rsp_data;
        tmsNext      = 1'b1;
        tdiNext      = 1'b0;

        if (state == IDLE) begin
            phaseNext = '0;
            tckNext   = 1'b0;
            if (!cmd_ready) begin
                // Completion cycle just ended; open for the next command.
                readyNext = 1'b1;
            end else if (cmd_valid) begin
                stateNext   = SEL_I;
                cntNext     = '0;
                isDataNext  = cmd_isData;
                // Instructions are left-aligned so tdi is always shifter[15].
                shifterNext = cmd_isData ? cmd_payload : {cmd_payload[7:0], 8'h00};
                captureNext = '0;
                readyNext   = 1'b0;
            end
        end else begin
            phaseNext = phase + 1'b1;
            if (phase == LOW_END) begin
                tckNext = 1'b1;
                if (state == SHIFT) begin
                    captureNext = {capture[14:0], tdo};
                end
            end
            if (phase == PERIOD_END) begin
                phaseNext = '0;
                tckNext   = 1'b0;
                case (state)
                    RST_SEQ: begin
                        if (cnt == 4'd3) begin
                            stateNext = IDLE;
                            readyNext = 1'b1;
                        end else begin
                            cntNext = cnt + 4'd1;
                        end
                    end
                    // SEL_I covers two periods: leaving Idle, then leaving Select-I.
                    SEL_I: begin
                        if (cnt == 4'd0) begin
                            cntNext = 4'd1;
                        end else begin
                            stateNext = isData ? SEL_D : SHIFT;
                            cntNext   = '0;
                        end
                    end
                    SEL_D: begin
                        stateNext = SHIFT;
                        cntNext   = '0;
                    end
                    SHIFT: begin
                        shifterNext = {shifter[14:0], 1'b0};
                        if (cnt == lastBit) begin
                            stateNext = UPDATE;
                        end else begin
                            cntNext = cnt + 4'd1;
                        end
                    end
                    UPDATE: begin
                        stateNext    = IDLE;
                        rspValidNext = 1'b1;
                        rspDataNext  = capture;
                    end
                    default: stateNext = RST_SEQ;
                endcase
            end
        end

        // tms/tdi for the period that the next state/count describe.
        case (stateNext)
            SEL_I: tmsNext = (cntNext == 4'd1) ? isDataNext : 1'b0;
            SEL_D: tmsNext = 1'b0;
            SHIFT: begin
                tmsNext = (cntNext == lastBitNext);
                tdiNext = shifterNext[15];
            end
            default: tmsNext = 1'b1;
        endcase
    end
endmodule
